// File: rtl/pipe_vector_checker.sv
// pipe_vector_checker: per-channel expected-vs-observed FIFO checker with
// per-channel latency, stall inhibit, error reporting and pass/done status.
//
// Parameters: WIDTH (field bits), NUM_CH (1..8), DEPTH (pow2 >= 2),
//   LAT_PACKED (4 bits per channel latency), ERRW (error counter width).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   vec_valid/vec_data  push one expected vector (channel c at [c*WIDTH +: WIDTH])
//   vec_last            marks final vector; an accepted one starts drain mode
//   obs                 observed DUT values, same packing as vec_data
//   stall               per-channel compare inhibit
//   err_valid/err_ch    one-cycle pulse + mismatching channel mask
//   err_exp             expected value of the lowest mismatching channel
//   err_count           saturating mismatch count
//   overflow            sticky: push refused (FIFO full or already done)
//   done / pass         sticky drain complete / done with no errors or overflow
// Optional macro CHECK_MASK_EN adds vec_mask: only mask-1 bits are compared.
module pipe_vector_checker #(
  parameter int          WIDTH      = 32,
  parameter int          NUM_CH     = 2,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] LAT_PACKED = 32'h0000_0010,
  parameter int          ERRW       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vec_valid,
  input  logic [NUM_CH*WIDTH-1:0] vec_data,
  input  logic                    vec_last,
`ifdef CHECK_MASK_EN
  input  logic [NUM_CH*WIDTH-1:0] vec_mask,
`endif
  input  logic [NUM_CH*WIDTH-1:0] obs,
  input  logic [NUM_CH-1:0]       stall,
  output logic                    err_valid,
  output logic [NUM_CH-1:0]       err_ch,
  output logic [WIDTH-1:0]        err_exp,
  output logic [ERRW-1:0]         err_count,
  output logic                    overflow,
  output logic                    done,
  output logic                    pass
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef CHECK_MASK_EN
  localparam int FW = 2 * WIDTH;
`else
  localparam int FW = WIDTH;
`endif

  logic [NUM_CH-1:0][WIDTH-1:0] headData;
  logic [NUM_CH-1:0][WIDTH-1:0] headMask;
  logic [NUM_CH-1:0]            full;
  logic [NUM_CH-1:0]            empty;
  logic [NUM_CH-1:0]            elig;
  logic [NUM_CH-1:0]            mis;
  logic                         drain;
  logic                         pushOk;
  logic                         allEmpty;
  logic [WIDTH-1:0]             expSel;
  logic [3:0]                   nMis;
  logic [ERRW:0]                sumCount;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_badCh
    $error("pipe_vector_checker: NUM_CH must be 1..8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("pipe_vector_checker: DEPTH must be a power of two >= 2");
  end

  // Once done, the run is closed: further pushes are refused.
  assign pushOk   = vec_valid && !(|full) && !done;
  assign allEmpty = &empty;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [3:0]    LatRaw = LAT_PACKED[4*c +: 4];
    localparam logic [CW-1:0] Lat    = CW'(LatRaw);

    if (LatRaw >= DEPTH) begin : g_badLat
      $error("pipe_vector_checker: LAT for a channel must be < DEPTH");
    end

    logic [FW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [CW-1:0]  cnt;
    logic [FW-1:0]  wrEntry;
    logic [FW-1:0]  rdEntry;
    logic [WIDTH-1:0] diff;

`ifdef CHECK_MASK_EN
    assign wrEntry     = {vec_mask[c*WIDTH +: WIDTH],
                          vec_data[c*WIDTH +: WIDTH]};
    assign headMask[c] = rdEntry[FW-1:WIDTH];
`else
    assign wrEntry     = vec_data[c*WIDTH +: WIDTH];
    assign headMask[c] = '1;
`endif

    assign rdEntry     = mem[rdPtr];
    assign headData[c] = rdEntry[WIDTH-1:0];
    assign full[c]     = (cnt == CW'(DEPTH));
    assign empty[c]    = (cnt == '0);

    // Entry must have aged past the channel latency, unless draining.
    assign elig[c] = !stall[c] && !empty[c] && ((cnt > Lat) || drain);

    // 4-state compare: X/Z on an unmasked obs bit counts as a mismatch.
    assign diff   = (headData[c] ^ obs[c*WIDTH +: WIDTH]) & headMask[c];
    assign mis[c] = elig[c] && (diff !== '0);

    always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr] <= wrEntry;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wrPtr <= '0;
        rdPtr <= '0;
        cnt   <= '0;
      end else begin
        if (pushOk)  wrPtr <= wrPtr + 1'b1;
        if (elig[c]) rdPtr <= rdPtr + 1'b1;
        unique case ({pushOk, elig[c]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_comb begin
    expSel = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mis[c]) expSel = headData[c];
    end
    nMis = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nMis = nMis + {3'b000, mis[c]};
    end
  end

  assign sumCount = {1'b0, err_count} + (ERRW+1)'(nMis);

  always_ff @(posedge clk) begin
    if (reset) begin
      drain     <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      err_valid <= 1'b0;
      err_ch    <= '0;
      err_exp   <= '0;
      err_count <= '0;
    end else begin
      if (pushOk && vec_last)  drain    <= 1'b1;
      if (vec_valid && !pushOk) overflow <= 1'b1;
      if (drain && allEmpty && !pushOk && !(|mis)) done <= 1'b1;
      err_valid <= |mis;
      err_ch    <= mis;
      if (|mis) begin
        err_exp   <= expSel;
        err_count <= sumCount[ERRW] ? '1 : sumCount[ERRW-1:0];
      end
    end
  end

  assign pass = done && (err_count == '0) && !overflow;

endmodule

// File: tb/tb_pipe_vector_checker.sv
// tb_pipe_vector_checker: queue-based reference model + scoreboard bench
// for pipe_vector_checker (NUM_CH=2, DEPTH=4, LAT ch0=0 ch1=1).
module tb_pipe_vector_checker;
  localparam int          W     = 32;
  localparam int          NCH   = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] LATP  = 32'h0000_0010;
  localparam int          ERRW  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vec_valid = 1'b0;
  logic vec_last = 1'b0;
  logic [NCH*W-1:0] vec_data = '0;
  logic [NCH*W-1:0] obs = '0;
  logic [NCH-1:0]   stall = '0;
`ifdef CHECK_MASK_EN
  logic [NCH*W-1:0] vec_mask = '1;
`endif
  logic             err_valid;
  logic [NCH-1:0]   err_ch;
  logic [W-1:0]     err_exp;
  logic [ERRW-1:0]  err_count;
  logic             overflow;
  logic             done;
  logic             pass;

  always #5 clk = ~clk;

  pipe_vector_checker #(
    .WIDTH(W), .NUM_CH(NCH), .DEPTH(DEPTH),
    .LAT_PACKED(LATP), .ERRW(ERRW)
  ) dut (
    .clk(clk), .reset(reset),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_last(vec_last),
`ifdef CHECK_MASK_EN
    .vec_mask(vec_mask),
`endif
    .obs(obs), .stall(stall),
    .err_valid(err_valid), .err_ch(err_ch), .err_exp(err_exp),
    .err_count(err_count), .overflow(overflow),
    .done(done), .pass(pass)
  );

  typedef struct packed {
    logic [NCH-1:0] ch;
    logic [W-1:0]   exp;
  } rec_t;

  logic [W-1:0] mq [NCH][$];
  rec_t sb[$];
  bit mDrain = 0;
  bit mDone = 0;
  bit mOvf = 0;
  int mErrs = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int latOf(int c);
    logic [31:0] p;
    p = LATP;
    return int'(p[4*c +: 4]);
  endfunction

  function automatic logic [NCH*W-1:0] echo();
    logic [NCH*W-1:0] o;
    o = '0;
    for (int c = 0; c < NCH; c++)
      if (mq[c].size() != 0) o[c*W +: W] = mq[c][0];
    return o;
  endfunction

  // One clock of stimulus; the model applies the same cycle's rules.
  task automatic step(input bit v, input logic [NCH*W-1:0] d,
                      input bit last, input logic [NCH-1:0] st,
                      input logic [NCH*W-1:0] o);
    bit acc, full, emp, nextDone;
    logic [NCH-1:0] mis;
    logic [W-1:0] ex;
    @(negedge clk);
    vec_valid = v; vec_data = d; vec_last = last;
    stall = st; obs = o;
    full = 0; emp = 1;
    for (int c = 0; c < NCH; c++) begin
      if (mq[c].size() >= DEPTH) full = 1;
      if (mq[c].size() != 0) emp = 0;
    end
    acc = v && !full && !mDone;
    if (v && !acc) mOvf = 1;
    nextDone = mDrain && emp && !acc;
    mis = '0; ex = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!st[c] && mq[c].size() != 0 &&
          (mq[c].size() > latOf(c) || mDrain)) begin
        if (mq[c][0] !== o[c*W +: W]) begin
          if (mis == '0) ex = mq[c][0];
          mis[c] = 1'b1;
          mErrs++;
        end
        void'(mq[c].pop_front());
      end
    end
    if (acc) begin
      for (int c = 0; c < NCH; c++) mq[c].push_back(d[c*W +: W]);
      if (last) mDrain = 1;
    end
    if (mis != '0) sb.push_back('{mis, ex});
    @(posedge clk);
    if (nextDone) mDone = 1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1; vec_valid = 0; vec_last = 0; stall = '0; obs = '0;
    for (int c = 0; c < NCH; c++) mq[c].delete();
    sb.delete();
    mDrain = 0; mDone = 0; mOvf = 0; mErrs = 0;
    @(posedge clk);
    #2 reset = 0;
  endtask

  task automatic drainOut(input bit rnd);
    logic [NCH*W-1:0] o;
    logic [NCH-1:0] st;
    for (int i = 0; i < 40 && !mDone; i++) begin
      o = echo();
      st = '0;
      if (rnd) begin
        st = NCH'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) o[31:0] = o[31:0] ^ $urandom;
        if ($urandom_range(0, 5) == 0) o[63:32] = o[63:32] ^ $urandom;
      end
      step(0, {$urandom, $urandom}, 0, st, o);
    end
    #2 chk("drain done", done, 1);
    if (rnd && $urandom_range(0, 1) == 1)
      step(1, {$urandom, $urandom}, 0, '0, echo());
    #2 chk("sb drained", sb.size(), 0);
  endtask

  task automatic stream(input int mode);
    logic [NCH*W-1:0] o;
    for (int i = 0; i < 4; i++) begin
      o = echo();
      if (mode == 1 && mq[1].size() != 0 && mq[1][0] == 32'd4)
        o[63:32] = 32'h0000_0BAD;
      if (mode == 3 && i == 2) o[31:0] = 'x;
      step(1, {W'(4*i), W'(4*i)}, i == 3,
           (mode == 2 && (i == 1 || i == 2)) ? 2'b10 : 2'b00, o);
    end
    drainOut(0);
  endtask

  task automatic randomRun(input int n);
    bit v, last;
    logic [NCH-1:0] st;
    logic [NCH*W-1:0] o;
    doReset();
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      if (last) step(0, '0, 0, '0, echo());
      v = last || ($urandom_range(0, 3) != 0);
      if (!v && $urandom_range(0, 3) == 0) last = 1;
      st = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, 3)) : '0;
      o = echo();
      if ($urandom_range(0, 7) == 0) o[31:0] = o[31:0] ^ $urandom;
      if ($urandom_range(0, 7) == 0) o[63:32] = o[63:32] ^ $urandom;
      step(v, {$urandom, $urandom}, last, st, o);
    end
    drainOut(1);
  endtask

  always @(posedge clk) begin
    rec_t r;
    #1;
    if (sb.size() != 0) begin
      r = sb.pop_front();
      chk("err_valid", err_valid, 1);
      chk("err_ch", err_ch, r.ch);
      chk("err_exp", err_exp, r.exp);
    end else begin
      chk("err_valid idle", err_valid, 0);
    end
    chk("err_count", err_count, mErrs[ERRW-1:0]);
    chk("done", done, mDone);
    chk("overflow", overflow, mOvf);
    chk("pass", pass, mDone && mErrs == 0 && !mOvf);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    doReset();
    chk("reset err_count", err_count, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);

    doReset(); stream(0);
    chk("clean pass", pass, 1);
    chk("clean err_count", err_count, 0);

    doReset(); stream(1);
    chk("bad err_count", err_count, 1);
    chk("bad pass", pass, 0);

    doReset(); stream(2);
    chk("stall err_count", err_count, 0);
    chk("stall pass", pass, 1);

    doReset(); stream(3);
    chk("x err_count", err_count, 1);

    doReset();
    for (int i = 0; i < 5; i++)
      step(1, {$urandom, $urandom}, 0, 2'b11, '0);
    #2 chk("ovf sticky", overflow, 1);
    step(0, '0, 0, 2'b00, echo());
    step(1, {$urandom, $urandom}, 1, 2'b00, echo());
    drainOut(0);
    chk("ovf pass", pass, 0);

    doReset();
    for (int i = 0; i < 3; i++)
      step(1, {$urandom, $urandom}, 0, 2'b11, '0);
    doReset();
    chk("rerun err_count", err_count, 0);
    step(1, {32'd20, 32'd16}, 0, 2'b00, echo());
    step(1, {32'd28, 32'd24}, 1, 2'b00, echo());
    drainOut(0);
    chk("rerun pass", pass, 1);

    for (int k = 0; k < 20; k++) randomRun($urandom_range(4, 20));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
